alu_writeback_stage: RTL and testbench

Downstream stage of the ALU. Captures each ALU result (ALU_Out, Zero) with its destination register tag into a small in-order buffer, then drains results to the register-file write port through a valid/ready handshake. Also provides combinational operand forwarding of buffered, not-yet-written results to the operand-fetch logic feeding the ALU. Provides back-pressure to the execute stage when full.

---
 rtl/alu_writeback_stage.sv | 175 +++++++++++++++++
 tb/tb_alu_writeback_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback_stage.sv
// ----------------------------------------------------------------------------
// alu_writeback_stage
//
// Sits after the ALU. Each accepted result (ALU_Out, Zero) is stored with its
// destination tag in a small in-order circular buffer and later drained to the
// register-file write port over a valid/ready handshake. Buffered results that
// will still be written are searched combinationally so operand fetch can
// forward them.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   In_Valid / In_Ready         result handshake from the execute stage
//   ALU_Out, Zero, Rd,          result payload: data, zero flag, dest register,
//   Reg_Write                   and whether the register file is written
//   Flush                       drop everything buffered (wins over push/pop)
//   WB_Valid / WB_Ready         register-file write handshake
//   WB_Addr, WB_Data, WB_Zero   head entry fields (zero when nothing to write)
//   Fwd_Addr1/2                 operand lookup addresses
//   Fwd_Hit1/2, Fwd_Data1/2     lookup result (youngest matching entry)
// ----------------------------------------------------------------------------
module alu_writeback_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [DATA_W-1:0] ALU_Out,
    input  logic              Zero,
    input  logic [ADDR_W-1:0] Rd,
    input  logic              Reg_Write,
    input  logic              Flush,
    output logic              WB_Valid,
    input  logic              WB_Ready,
    output logic [ADDR_W-1:0] WB_Addr,
    output logic [DATA_W-1:0] WB_Data,
    output logic              WB_Zero,
    input  logic [ADDR_W-1:0] Fwd_Addr1,
    input  logic [ADDR_W-1:0] Fwd_Addr2,
    output logic              Fwd_Hit1,
    output logic [DATA_W-1:0] Fwd_Data1,
    output logic              Fwd_Hit2,
    output logic [DATA_W-1:0] Fwd_Data2
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Entry storage. Payload fields carry no reset; occupancy is defined by
    // count/pointers and the write-enable bits are cleared on reset.
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic              zero_mem [DEPTH];
    logic [ADDR_W-1:0] rd_mem   [DEPTH];
    logic [DEPTH-1:0]  wr_reg;

    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]  count_reg,  count_next;

    logic [DEPTH-1:0]  live_vec;
    logic              head_live;
    logic              push;
    logic              pop;

    // An entry is live when it is currently occupied (its distance from the
    // read pointer is below count), requests a write, and targets a nonzero
    // register. Dead entries still occupy a slot until they retire.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_live
            logic [PTR_W-1:0] age;
            assign age          = PTR_W'(gi) - rd_ptr_reg;
            assign live_vec[gi] = wr_reg[gi] && (rd_mem[gi] != '0)
                                  && (CNT_W'(age) < count_reg);
        end
    endgenerate

    // live_vec already folds in occupancy, so this is 0 when empty.
    assign head_live = live_vec[rd_ptr_reg];

    // Depends only on registered state: a full buffer never accepts, even if
    // the head is being written this cycle.
    assign In_Ready = (count_reg < CNT_W'(DEPTH));

    assign push = In_Valid && In_Ready && !Flush;
    // Dead heads retire on their own, one per cycle; live heads wait for
    // the register file.
    assign pop  = (count_reg != '0) && !Flush && (!head_live || WB_Ready);

    assign WB_Valid = head_live && !Flush;
    assign WB_Addr  = head_live ? rd_mem[rd_ptr_reg]   : '0;
    assign WB_Data  = head_live ? data_mem[rd_ptr_reg] : '0;
    assign WB_Zero  = head_live ? zero_mem[rd_ptr_reg] : 1'b0;

    // ------------------------------------------------------------------
    // Pointer / occupancy update
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (Flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            wr_reg     <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            if (push) begin
                wr_reg[wr_ptr_reg] <= Reg_Write;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= ALU_Out;
            zero_mem[wr_ptr_reg] <= Zero;
            rd_mem[wr_ptr_reg]   <= Rd;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding: walk from oldest to youngest so the youngest match wins.
    // The entry arriving on In_Valid this cycle is deliberately not seen.
    // ------------------------------------------------------------------
    function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] addr);
        logic [DATA_W:0]  result;
        logic [PTR_W-1:0] idx;
        result = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_reg + PTR_W'(k);
            if (live_vec[idx] && (addr != '0) && (rd_mem[idx] == addr)) begin
                result = {1'b1, data_mem[idx]};
            end
        end
        return result;
    endfunction

    always_comb begin
        logic [DATA_W:0] r1;
        logic [DATA_W:0] r2;
        r1        = fwd_lookup(Fwd_Addr1);
        r2        = fwd_lookup(Fwd_Addr2);
        Fwd_Hit1  = r1[DATA_W];
        Fwd_Data1 = r1[DATA_W-1:0];
        Fwd_Hit2  = r2[DATA_W];
        Fwd_Data2 = r2[DATA_W-1:0];
    end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// ----------------------------------------------------------------------------
// Testbench for alu_writeback_stage: directed scenarios followed by random
// traffic. A queue-based reference model predicts readiness, write-port
// validity and forwarding; expected register-file writes go into a scoreboard
// queue that an independent monitor drains whenever the DUT performs a write.
// ----------------------------------------------------------------------------
module tb_alu_writeback_stage;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              In_Valid;
    logic              In_Ready;
    logic [DATA_W-1:0] ALU_Out;
    logic              Zero;
    logic [ADDR_W-1:0] Rd;
    logic              Reg_Write;
    logic              Flush;
    logic              WB_Valid;
    logic              WB_Ready;
    logic [ADDR_W-1:0] WB_Addr;
    logic [DATA_W-1:0] WB_Data;
    logic              WB_Zero;
    logic [ADDR_W-1:0] Fwd_Addr1;
    logic [ADDR_W-1:0] Fwd_Addr2;
    logic              Fwd_Hit1;
    logic [DATA_W-1:0] Fwd_Data1;
    logic              Fwd_Hit2;
    logic [DATA_W-1:0] Fwd_Data2;

    alu_writeback_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .In_Valid(In_Valid), .In_Ready(In_Ready),
        .ALU_Out(ALU_Out), .Zero(Zero), .Rd(Rd), .Reg_Write(Reg_Write),
        .Flush(Flush),
        .WB_Valid(WB_Valid), .WB_Ready(WB_Ready),
        .WB_Addr(WB_Addr), .WB_Data(WB_Data), .WB_Zero(WB_Zero),
        .Fwd_Addr1(Fwd_Addr1), .Fwd_Addr2(Fwd_Addr2),
        .Fwd_Hit1(Fwd_Hit1), .Fwd_Data1(Fwd_Data1),
        .Fwd_Hit2(Fwd_Hit2), .Fwd_Data2(Fwd_Data2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              z;
        logic [ADDR_W-1:0] rd;
        logic              rw;
    } ent_t;

    ent_t mq[$];     // model of every buffered entry, oldest first
    ent_t exp_q[$];  // expected register-file writes, in order

    int tests = 0;
    int fails = 0;
    int writes = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference forwarding: youngest buffered entry that will really write.
    task automatic fwd_model(input logic [ADDR_W-1:0] a, output logic hit,
                             output logic [DATA_W-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != 0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].rw && mq[i].rd != 0 && mq[i].rd == a) begin
                    hit = 1'b1;
                    d   = mq[i].d;
                    break;
                end
            end
        end
    endtask

    // Model / combinational checker: runs just after the falling edge,
    // then advances the model to what the next rising edge should produce.
    always @(negedge clk) begin
        logic              exp_ready;
        logic              head_live;
        logic              h1, h2;
        logic [DATA_W-1:0] d1, d2;
        ent_t              e;
        #1;
        if (rst) begin
            mq.delete();
            exp_q.delete();
        end else begin
            exp_ready = (mq.size() < DEPTH);
            head_live = (mq.size() > 0) && mq[0].rw && (mq[0].rd != 0);
            chk("in_ready", In_Ready, exp_ready);
            chk("wb_valid", WB_Valid, head_live && !Flush);
            if (mq.size() == 0) begin
                chk("wb_idle_fields", {WB_Zero, WB_Addr, WB_Data}, '0);
            end
            fwd_model(Fwd_Addr1, h1, d1);
            fwd_model(Fwd_Addr2, h2, d2);
            chk("fwd1", {Fwd_Hit1, Fwd_Data1}, {h1, d1});
            chk("fwd2", {Fwd_Hit2, Fwd_Data2}, {h2, d2});

            if (Flush) begin
                mq.delete();
                exp_q.delete();
            end else begin
                if (mq.size() > 0 && (!head_live || WB_Ready)) begin
                    void'(mq.pop_front());
                end
                if (In_Valid && exp_ready) begin
                    e.d  = ALU_Out;
                    e.z  = Zero;
                    e.rd = Rd;
                    e.rw = Reg_Write;
                    mq.push_back(e);
                    if (Reg_Write && Rd != 0) begin
                        exp_q.push_back(e);
                    end
                end
            end
        end
    end

    // Write monitor: every completed register-file write is checked against
    // the scoreboard head.
    always @(negedge clk) begin
        ent_t e;
        if (!rst && WB_Valid && WB_Ready) begin
            if (Flush) begin
                chk("write_during_flush", 1, 0);
            end else if (exp_q.size() == 0) begin
                chk("unexpected_write", {WB_Addr, WB_Data}, '0);
            end else begin
                e = exp_q.pop_front();
                writes++;
                $display("[TB] write rd=%0d data=0x%08h zero=%0d", WB_Addr, WB_Data, WB_Zero);
                chk("wb_addr", WB_Addr, e.rd);
                chk("wb_data", WB_Data, e.d);
                chk("wb_zero", WB_Zero, e.z);
            end
        end
    end

    task automatic drive(input logic iv, input logic [DATA_W-1:0] d, input logic z,
                         input logic [ADDR_W-1:0] rd, input logic rw, input logic wbr,
                         input logic fl, input logic r,
                         input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
        @(posedge clk);
        #1;
        In_Valid  = iv;
        ALU_Out   = d;
        Zero      = z;
        Rd        = rd;
        Reg_Write = rw;
        WB_Ready  = wbr;
        Flush     = fl;
        rst       = r;
        Fwd_Addr1 = a1;
        Fwd_Addr2 = a2;
    endtask

    task automatic idle(input logic wbr, input int n);
        for (int i = 0; i < n; i++) drive(0, '0, 0, 0, 0, wbr, 0, 0, 3, 7);
    endtask

    initial begin
        rst = 1; In_Valid = 0; ALU_Out = '0; Zero = 0; Rd = '0; Reg_Write = 0;
        Flush = 0; WB_Ready = 0; Fwd_Addr1 = '0; Fwd_Addr2 = '0;
        drive(0, '0, 0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, '0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(1, 1);

        // single result, drained the next cycle
        drive(1, 32'h5, 0, 3, 1, 1, 0, 0, 3, 0);
        idle(1, 2);

        // back-pressure: two fill the buffer, third is refused
        drive(1, 32'hA, 0, 1, 1, 0, 0, 0, 1, 2);
        drive(1, 32'hB, 0, 2, 1, 0, 0, 0, 1, 2);
        drive(1, 32'hC, 1, 5, 1, 0, 0, 0, 1, 2);
        idle(0, 1);
        idle(1, 3);

        // entries that never write retire silently
        drive(1, 32'hFFFF_FFFF, 0, 0, 1, 1, 0, 0, 0, 6);
        drive(1, 32'h1234, 1, 6, 0, 1, 0, 0, 0, 6);
        idle(1, 3);

        // two pending writes to the same register: youngest forwards
        drive(1, 32'h11, 0, 7, 1, 0, 0, 0, 7, 0);
        drive(1, 32'h22, 0, 7, 1, 0, 0, 0, 7, 0);
        drive(0, '0, 0, 0, 0, 0, 0, 0, 7, 0);

        // flush a full buffer while a write and a push are offered
        drive(1, 32'h99, 0, 9, 1, 1, 1, 0, 7, 9);
        idle(1, 2);

        // reset with pending writes, then normal operation resumes
        drive(1, 32'h44, 0, 4, 1, 0, 0, 0, 4, 8);
        drive(1, 32'h88, 1, 8, 1, 0, 0, 0, 4, 8);
        drive(0, '0, 0, 0, 0, 1, 0, 1, 4, 8);
        drive(1, 32'h3, 0, 4, 1, 1, 0, 0, 4, 8);
        idle(1, 2);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, 1'($urandom),
                  ADDR_W'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 99) < 3,
                  $urandom_range(0, 199) == 0,
                  ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)));
        end

        idle(1, 6);
        chk("drain_empty", exp_q.size(), 0);
        chk("writes_seen", writes > 10, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
